// File: rtl/ed25519_pkg.sv
// Shared constants and FSM state type for the ed25519 stream front end.
package ed25519_pkg;

    localparam int DATA_W    = 64;
    localparam int PATN_W    = 256;
    localparam int IN_BEATS  = 12;
    localparam int OUT_BEATS = 8;

    typedef enum logic [1:0] {
        S_RECV,
        S_START,
        S_WAIT,
        S_SEND
    } io_state_t;

endpackage

// File: rtl/ed25519_out_ser.sv
// Result serializer: 512-bit load/shift register emitting MS word first, plus beat counter.
module ed25519_out_ser
    import ed25519_pkg::*;
#(
    parameter int DATA_W = ed25519_pkg::DATA_W,
    parameter int PATN_W = ed25519_pkg::PATN_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [2*PATN_W-1:0]   i_load_data,
    input  logic                  i_shift,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_last
);

    localparam logic [2:0] LAST_BEAT = 3'(OUT_BEATS - 1);

    logic [2*PATN_W-1:0] sr_q;
    logic [2:0]          cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            sr_q  <= i_load_data;
            cnt_q <= '0;
        end else if (i_shift) begin
            // Counter wraps to zero on the final beat, leaving it cleared for the next result.
            sr_q  <= {sr_q[2*PATN_W-DATA_W-1:0], {DATA_W{1'b0}}};
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign o_data = sr_q[2*PATN_W-1 -: DATA_W];
    assign o_last = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/ed25519_io_ctrl.sv
// Stream front end: deserializes 12x64-bit operands, starts the core, serializes the 512-bit result.
// Optional macro ED25519_IO_OVERLAP_EN accepts the next operands while the result drains.
module ed25519_io_ctrl
    import ed25519_pkg::*;
#(
    parameter int DATA_W = ed25519_pkg::DATA_W,
    parameter int PATN_W = ed25519_pkg::PATN_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_start,
    output logic [PATN_W-1:0] o_scalar,
    output logic [PATN_W-1:0] o_px,
    output logic [PATN_W-1:0] o_py,
    input  logic              i_done,
    input  logic [PATN_W-1:0] i_rx,
    input  logic [PATN_W-1:0] i_ry
);

    localparam int         OP_W    = 3 * PATN_W;
    localparam logic [3:0] IN_FULL = 4'(IN_BEATS);

    io_state_t         state_q, state_d;
    logic [3:0]        in_cnt_q, in_cnt_d;
    logic [OP_W-1:0]   op_q;
    logic              in_ready;
    logic              accept;
    logic              shift;
    logic              load;
    logic              ser_last;
    logic [DATA_W-1:0] ser_data;

`ifdef ED25519_IO_OVERLAP_EN
    assign in_ready = (state_q == S_RECV) || ((state_q == S_SEND) && (in_cnt_q != IN_FULL));
`else
    assign in_ready = (state_q == S_RECV);
`endif

    // Ready is held low during reset even though the state register already reads S_RECV.
    assign o_in_ready  = in_ready & ~i_rst;
    assign accept      = i_in_valid & o_in_ready;
    assign o_out_valid = (state_q == S_SEND);
    assign o_start     = (state_q == S_START);
    assign shift       = o_out_valid & i_out_ready;
    assign o_out_data  = o_out_valid ? ser_data : '0;

    assign o_scalar = op_q[OP_W-1          -: PATN_W];
    assign o_px     = op_q[OP_W-PATN_W-1   -: PATN_W];
    assign o_py     = op_q[PATN_W-1:0];

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        in_cnt_d = accept ? (in_cnt_q + 4'd1) : in_cnt_q;
        unique case (state_q)
            S_RECV: begin
                if (in_cnt_d == IN_FULL) begin
                    state_d  = S_START;
                    in_cnt_d = '0;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_done) begin
                    load    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (shift && ser_last) begin
`ifdef ED25519_IO_OVERLAP_EN
                    if (in_cnt_d == IN_FULL) begin
                        state_d  = S_START;
                        in_cnt_d = '0;
                    end else begin
                        state_d = S_RECV;
                    end
`else
                    state_d  = S_RECV;
                    in_cnt_d = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_RECV;
            in_cnt_q <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            if (accept)
                op_q[OP_W-1-DATA_W*int'(in_cnt_q) -: DATA_W] <= i_in_data;
        end
    end

    ed25519_out_ser #(
        .DATA_W (DATA_W),
        .PATN_W (PATN_W)
    ) u_out_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_load_data ({i_rx, i_ry}),
        .i_shift     (shift),
        .o_data      (ser_data),
        .o_last      (ser_last)
    );

endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// Scoreboard bench for ed25519_io_ctrl: driver pushes expected operands/beats, monitor pops and compares.
module tb_ed25519_io_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [63:0]  i_in_data;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [63:0]  o_out_data;
    logic         o_start;
    logic [255:0] o_scalar, o_px, o_py;
    logic         i_done;
    logic [255:0] i_rx, i_ry;

    ed25519_io_ctrl #(.DATA_W(64), .PATN_W(256)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_start     (o_start),
        .o_scalar    (o_scalar),
        .o_px        (o_px),
        .o_py        (o_py),
        .i_done      (i_done),
        .i_rx        (i_rx),
        .i_ry        (i_ry)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] s;
        logic [255:0] x;
        logic [255:0] y;
    } ops_t;

    ops_t        start_q[$];
    logic [63:0] out_q[$];
    int          checks = 0;
    int          errors = 0;
    int          out_mode = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ops_t mk_ops(input logic [63:0] b);
        ops_t o;
        o.s = {b,          b + 64'd1,  b + 64'd2,  b + 64'd3};
        o.x = {b + 64'd4,  b + 64'd5,  b + 64'd6,  b + 64'd7};
        o.y = {b + 64'd8,  b + 64'd9,  b + 64'd10, b + 64'd11};
        return o;
    endfunction

    always @(posedge i_clk) begin
        #1;
        case (out_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = 1'($urandom_range(0, 1));
            default: i_out_ready = 1'b0;
        endcase
    end

    // Monitor: compares every start and every presented output beat against the scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_start) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_start", 256'd1, 256'd0);
                end else begin
                    ops_t e;
                    e = start_q.pop_front();
                    chk("scalar", o_scalar, e.s);
                    chk("px", o_px, e.x);
                    chk("py", o_py, e.y);
                end
            end
            if (o_out_valid) begin
                if (out_q.size() == 0)
                    chk("unexpected_out_valid", 256'd1, 256'd0);
                else if (i_out_ready)
                    chk("out_beat", {192'd0, o_out_data}, {192'd0, out_q.pop_front()});
                else
                    chk("out_stall_stable", {192'd0, o_out_data}, {192'd0, out_q[0]});
            end else begin
                chk("out_data_idle_zero", {192'd0, o_out_data}, 256'd0);
            end
        end
    end

    task automatic send_txn(input logic [63:0] base, input int n, input bit rnd,
                            input bit tcheck, input bit done_coinc);
        int k     = 0;
        int guard = 0;
        bit acc   = 1'b0;
        if (n == 12) start_q.push_back(mk_ops(base));
        while (guard < 2000) begin
            @(posedge i_clk); #1;
            guard++;
            if (acc) k++;
            if (k == n) break;
            i_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_in_data  = base + 64'(k);
            @(negedge i_clk);
            acc = i_in_valid && o_in_ready;
        end
        i_in_valid = 1'b0;
        i_in_data  = '0;
        if (k < n) chk("send_timeout", 256'(k), 256'(n));
        if (done_coinc) i_done = 1'b1;
        if (tcheck) begin
            @(negedge i_clk);
            chk("start_after_last_accept", {255'd0, o_start}, 256'd1);
        end
        if (done_coinc) begin
            @(posedge i_clk); #1;
            i_done = 1'b0;
        end
    endtask

    task automatic core(input logic [63:0] a, input logic [63:0] b);
        @(posedge i_clk); #1;
        i_rx = {a, a + 64'd1, a + 64'd2, a + 64'd3};
        i_ry = {b, b + 64'd1, b + 64'd2, b + 64'd3};
        for (int i = 0; i < 4; i++) out_q.push_back(a + 64'(i));
        for (int i = 0; i < 4; i++) out_q.push_back(b + 64'(i));
        i_done = 1'b1;
        @(posedge i_clk); #1;
        i_done = 1'b0;
    endtask

    task automatic drain(input bit exp8, input bit start_after);
        int hs    = 0;
        int cyc   = 0;
        int guard = 0;
        while (hs < 8 && guard < 2000) begin
            @(negedge i_clk);
            guard++;
            if (o_out_valid) begin
                cyc++;
`ifndef ED25519_IO_OVERLAP_EN
                chk("in_ready_low_in_send", {255'd0, o_in_ready}, 256'd0);
`endif
                if (i_out_ready) hs++;
            end
        end
        if (hs < 8) chk("drain_timeout", 256'(hs), 256'd8);
        if (exp8) chk("drain_cycles", 256'(cyc), 256'd8);
        @(negedge i_clk);
        if (start_after)
            chk("start_after_drain", {255'd0, o_start}, 256'd1);
        else
            chk("in_ready_after_drain", {255'd0, o_in_ready}, 256'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  {255'd0, o_in_ready},  256'd0);
        chk({tag, "_out_valid"}, {255'd0, o_out_valid}, 256'd0);
        chk({tag, "_start"},     {255'd0, o_start},     256'd0);
        chk({tag, "_out_data"},  {192'd0, o_out_data},  256'd0);
        chk({tag, "_scalar"},    o_scalar, 256'd0);
        chk({tag, "_px"},        o_px,     256'd0);
        chk({tag, "_py"},        o_py,     256'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        i_rst      = 1'b1;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_done     = 1'b0;
        i_rx       = '0;
        i_ry       = '0;
        i_out_ready = 1'b1;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk_all_zero("reset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("in_ready_after_release", {255'd0, o_in_ready}, 256'd1);

        // Directed transaction: beats 1..C, result A0..A3 / B0..B3.
        send_txn(64'h1, 12, 1'b0, 1'b1, 1'b0);
        core(64'hA0, 64'hB0);
        drain(1'b1, 1'b0);

        // Same transaction with 50% valid / ready bubbles.
        out_mode = 1;
        send_txn(64'h1, 12, 1'b1, 1'b1, 1'b0);
        core(64'hA0, 64'hB0);
        drain(1'b0, 1'b0);
        out_mode = 0;

        // i_done in S_RECV and coincident with o_start must be ignored.
        @(posedge i_clk); #1;
        i_done = 1'b1;
        @(posedge i_clk); #1;
        i_done = 1'b0;
        @(negedge i_clk);
        chk("no_valid_done_in_recv", {255'd0, o_out_valid}, 256'd0);
        send_txn(64'h11, 12, 1'b0, 1'b1, 1'b1);
        repeat (4) begin
            @(negedge i_clk);
            chk("no_valid_done_with_start", {255'd0, o_out_valid}, 256'd0);
        end
        core(64'hC0, 64'hD0);
        drain(1'b1, 1'b0);

        // Reset after 5 beats discards the partial operands.
        send_txn(64'h31, 5, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        chk("partial_scalar_loaded", o_scalar,
            {64'h31, 64'h32, 64'h33, 64'h34});
        #2;
        i_rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("in_ready_after_midreset", {255'd0, o_in_ready}, 256'd1);
        send_txn(64'h41, 12, 1'b0, 1'b1, 1'b0);
        core(64'hE0, 64'hF0);
        drain(1'b1, 1'b0);

`ifdef ED25519_IO_OVERLAP_EN
        // Next operands arrive while the stalled result is still held.
        send_txn(64'h51, 12, 1'b0, 1'b1, 1'b0);
        out_mode = 2;
        core(64'h60, 64'h70);
        send_txn(64'h81, 12, 1'b0, 1'b0, 1'b0);
        out_mode = 0;
        drain(1'b0, 1'b1);
        core(64'h90, 64'hA8);
        drain(1'b1, 1'b0);
`endif

        repeat (3) @(negedge i_clk);
        chk("out_queue_empty",   256'(out_q.size()),   256'd0);
        chk("start_queue_empty", 256'(start_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ed25519_io_ctrl.md
# ed25519_io_ctrl

Stream front end of the ed25519 accelerator. It deserializes the 12-beat, 64-bit valid/ready input stream into the 256-bit scalar and point operands, then starts the point-multiply core. It captures the core's 512-bit result and serializes it as an 8-beat valid/ready output stream. It sits between the `ed25519` top-level ports and the arithmetic core.

## Interface
- `DATA_W`, 64: stream beat width.
- `PATN_W`, 256: operand/coordinate width.
- `i_clk` in 1: single clock; all logic rising-edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_in_valid` in 1: input beat valid.
- `o_in_ready` out 1: input beat accepted when `i_in_valid & o_in_ready`.
- `i_in_data` in `DATA_W`: input beat.
- `o_out_valid` out 1: output beat valid.
- `i_out_ready` in 1: output beat consumed when `o_out_valid & i_out_ready`.
- `o_out_data` out `DATA_W`: output beat.
- `o_start` out 1: one-cycle pulse; operands valid.
- `o_scalar`, `o_px`, `o_py` out `PATN_W` each: operand registers.
- `i_done` in 1: core result-valid pulse.
- `i_rx`, `i_ry` in `PATN_W` each: core result coordinates.

## Operation
- FSM states: `S_RECV`, `S_START`, `S_WAIT`, `S_SEND`. Reset state is `S_RECV`.
- Input order is scalar, then x, then y, most-significant 64-bit word first within each. Beat k (0..11) lands at bits `[767-64k -: 64]` of the 768-bit concatenation {scalar, px, py}.
- `S_RECV`:
  - `o_in_ready`=1.
  - A 4-bit beat counter increments on each accept.
  - The 12th accept (count 11) moves the FSM to `S_START`.
- `S_START`:
  - `o_start`=1 for exactly one cycle.
  - Next state is `S_WAIT`.
- `S_WAIT`:
  - On `i_done`=1, load {`i_rx`, `i_ry`} into the output shift register.
  - Next state is `S_SEND`.
- `S_SEND`:
  - `o_out_valid`=1.
  - `o_out_data` = shift-register bits `[511:448]`.
  - On each handshake, shift left by 64 and increment the 3-bit output counter.
  - After the 8th handshake, return to `S_RECV`. Counters are cleared.
- `i_done` is ignored outside `S_WAIT`. This includes a pulse coincident with `o_start`.
- Operand registers hold their values from `o_start` until at least `i_done`. They are written only by accepted input beats.
- While `o_out_valid`=0, `o_out_data` = 0.
- Back-to-back transactions need no idle cycles or reset between them.

## Timing
- Reset values:
  - `o_in_ready`=0 while `i_rst`=1; it is 1 in the first cycle after release (`S_RECV`).
  - `o_out_valid`=0, `o_start`=0, `o_out_data`=0.
  - `o_scalar`/`o_px`/`o_py`=0; counters are 0.
- `o_start` is asserted in the cycle after the 12th input accept.
- `o_out_valid` is asserted in the cycle after `i_done` is sampled in `S_WAIT`.
- Minimum output time is 8 cycles with `i_out_ready` held at 1.
- Backpressure: while `o_out_valid`=1 and `i_out_ready`=0, `o_out_data` and the counter stay stable.
- Input bubbles (`i_in_valid`=0) stall the beat counter with no data corruption.
- `o_in_ready` and `o_out_valid` are registered-state decodes only. Neither depends combinationally on `i_in_valid` or `i_out_ready`.
- Reset asserted mid-transaction:
  - All state returns to reset values immediately (asynchronously).
  - Partially received beats are discarded.
  - A pending output is dropped.

## Configuration
- `ED25519_IO_OVERLAP_EN` defined:
  - `o_in_ready` is also 1 in `S_SEND`, so the next transaction's beats are accepted into the operand registers while the result drains.
  - `o_in_ready` drops once 12 beats are held.
  - On the final output handshake, the FSM goes to `S_START` if 12 beats are held, otherwise to `S_RECV` with the count preserved.
- `ED25519_IO_OVERLAP_EN` undefined: `o_in_ready`=0 in `S_START`, `S_WAIT` and `S_SEND`.

## Structure
- Package `ed25519_pkg` holds:
  - `DATA_W`, `PATN_W`, `IN_BEATS`=12, `OUT_BEATS`=8.
  - The `io_state_t` enum.
- Sub-module `ed25519_out_ser`:
  - Contains the 512-bit load/shift register and the 3-bit beat counter.
  - Ports: load, shift, last flag.
- FSM and input deserializer stay in `ed25519_io_ctrl`.

## Test plan
- Reset, then send beats `64'h1`..`64'hC` continuously -> `o_start` pulses once, one cycle after the accept of beat `64'hC`, with:
  - `o_scalar`=`{64'h1,64'h2,64'h3,64'h4}`
  - `o_px`=`{64'h5..64'h8}`
  - `o_py`=`{64'h9..64'hC}`
- Core model returns `i_rx`=`256'hA0..A3`, `i_ry`=`256'hB0..B3` (words) with `i_out_ready`=1 -> output beats `64'hA0,A1,A2,A3,B0,B1,B2,B3` on 8 consecutive cycles, then `o_in_ready`=1.
- Random `i_in_valid`/`i_out_ready` at 50% -> identical operands and output beat sequence; `o_out_data` constant across every stalled cycle.
- `i_done` pulsed during `S_RECV` and coincident with `o_start` -> no `o_out_valid`; a later `i_done` is captured normally.
- `i_rst` pulsed after 5 input beats -> all outputs return to 0; next 12 fresh beats produce a correct `o_start` and operands.
- With `ED25519_IO_OVERLAP_EN` defined: send all 12 beats of transaction 2 while transaction 1 drains -> `o_start` in the cycle after transaction 1's 8th output handshake. Without the macro, `o_in_ready` stays 0 throughout `S_SEND`.
